// File: rtl/duck_pkg.sv
// Shared types and constants for the duck sprite controller: FSM state
// encoding, palette indices and sprite frame numbers.
package duck_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FLY    = 3'd1,
    S_HIT    = 3'd2,
    S_FALL   = 3'd3,
    S_ESCAPE = 3'd4,
    S_DONE   = 3'd5
  } duck_state_e;

  localparam logic [3:0] IDX_TRANSPARENT = 4'hF;
  localparam logic [3:0] IDX_FLASH       = 4'h1;

  localparam logic [1:0] FRAME_FLAP0 = 2'd0;
  localparam logic [1:0] FRAME_FLAP1 = 2'd1;
  localparam logic [1:0] FRAME_HIT   = 2'd2;
  localparam logic [1:0] FRAME_FALL  = 2'd3;

endpackage

// File: rtl/duck_sprite_rom.sv
// Duck sprite storage: 4 frames of SPRITE_H x SPRITE_W 4-bit palette indices,
// synchronous read with one cycle of latency. Address is {frame, row, col}.
module duck_sprite_rom
  import duck_pkg::*;
#(
  parameter int SPRITE_W = 32,
  parameter int SPRITE_H = 32,
  localparam int XW = $clog2(SPRITE_W),
  localparam int YW = $clog2(SPRITE_H),
  localparam int AW = 2 + XW + YW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] addr,
  output logic [3:0]    data
);

  logic [1:0]    frame;
  logic [YW-1:0] row;
  logic [XW-1:0] col;

  assign {frame, row, col} = addr;

  // Generated sprite art: a diagonal band pattern that differs per frame and
  // contains transparent (4'hF) texels in every frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      data <= IDX_TRANSPARENT;
    end else begin
      data <= 4'(col[XW-1:1]) + 4'(row[YW-1:1]) + {frame, 2'b00}
              + {3'b000, col[0] & row[0]};
    end
  end

endmodule

// File: rtl/duck_sprite_ctrl.sv
// Duck Hunt style duck controller: flight FSM, hit/escape handling and a
// 2-cycle sprite pixel path. Define DUCK_HIT_FLASH_EN to flash the hit sprite.
module duck_sprite_ctrl
  import duck_pkg::*;
#(
  parameter int SPRITE_W      = 32,
  parameter int SPRITE_H      = 32,
  parameter int SCREEN_W      = 640,
  parameter int GROUND_Y      = 400,
  parameter int FLY_SPEED     = 2,
  parameter int FALL_SPEED    = 4,
  parameter int FLAP_PERIOD   = 8,
  parameter int HIT_FRAMES    = 30,
  parameter int ESCAPE_FRAMES = 600
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       start,
  input  logic [9:0] start_x,
  input  logic       start_dir,
  input  logic       shot,
  input  logic [9:0] shot_x,
  input  logic [9:0] shot_y,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  output logic [3:0] color_idx,
  output logic       duck_pixel,
  output logic [9:0] duck_x,
  output logic [9:0] duck_y,
  output logic [2:0] state,
  output logic       hit,
  output logic       escaped
);

  localparam int XW   = $clog2(SPRITE_W);
  localparam int YW   = $clog2(SPRITE_H);
  localparam int AW   = 2 + XW + YW;
  localparam int FT_W = $clog2(ESCAPE_FRAMES + 1);
  localparam int HT_W = ($clog2(HIT_FRAMES + 1) > 3) ? $clog2(HIT_FRAMES + 1) : 3;
  localparam int FP_W = (FLAP_PERIOD > 2) ? $clog2(FLAP_PERIOD) : 1;

  localparam logic [10:0] X_MAX  = 11'(SCREEN_W - SPRITE_W);
  localparam logic [10:0] Y_MAX  = 11'(GROUND_Y);
  localparam logic [10:0] FLY_D  = 11'(FLY_SPEED);
  localparam logic [10:0] FALL_D = 11'(FALL_SPEED);

  duck_state_e     state_q, state_d;
  logic [9:0]      x_q, x_d, y_q, y_d;
  logic            dir_x_q, dir_x_d;   // 1 = right
  logic            dir_y_q, dir_y_d;   // 1 = up
  logic [FT_W-1:0] fly_t_q, fly_t_d;
  logic [HT_W-1:0] hit_t_q, hit_t_d;
  logic [FP_W-1:0] flap_cnt_q, flap_cnt_d;
  logic            flap_q, flap_d;
  logic            hit_d, esc_d;
  logic [10:0]     nx, ny;
  logic            shot_in_box;

  assign shot_in_box = shot && (state_q == S_FLY)
                    && ({1'b0, shot_x} >= {1'b0, x_q})
                    && ({1'b0, shot_x} <  {1'b0, x_q} + 11'(SPRITE_W))
                    && ({1'b0, shot_y} >= {1'b0, y_q})
                    && ({1'b0, shot_y} <  {1'b0, y_q} + 11'(SPRITE_H));

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    dir_x_d    = dir_x_q;
    dir_y_d    = dir_y_q;
    fly_t_d    = fly_t_q;
    hit_t_d    = hit_t_q;
    flap_cnt_d = flap_cnt_q;
    flap_d     = flap_q;
    hit_d      = 1'b0;
    esc_d      = 1'b0;
    nx         = {1'b0, x_q};
    ny         = {1'b0, y_q};
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d    = S_FLY;
          x_d        = ({1'b0, start_x} > X_MAX) ? X_MAX[9:0] : start_x;
          y_d        = Y_MAX[9:0];
          dir_x_d    = start_dir;
          dir_y_d    = 1'b1;
          fly_t_d    = '0;
          hit_t_d    = '0;
          flap_cnt_d = '0;
          flap_d     = 1'b0;
        end
      end
      S_FLY: begin
        // A valid hit takes priority over movement and timer expiry.
        if (shot_in_box) begin
          state_d = S_HIT;
          hit_d   = 1'b1;
          hit_t_d = '0;
        end else if (frame_tick) begin
          if (dir_x_q) begin
            nx = {1'b0, x_q} + FLY_D;
            if (nx >= X_MAX) begin nx = X_MAX; dir_x_d = 1'b0; end
          end else if ({1'b0, x_q} <= FLY_D) begin
            nx = '0; dir_x_d = 1'b1;
          end else begin
            nx = {1'b0, x_q} - FLY_D;
          end
          if (dir_y_q) begin
            if ({1'b0, y_q} <= FLY_D) begin ny = '0; dir_y_d = 1'b0; end
            else ny = {1'b0, y_q} - FLY_D;
          end else begin
            ny = {1'b0, y_q} + FLY_D;
            if (ny >= Y_MAX) begin ny = Y_MAX; dir_y_d = 1'b1; end
          end
          x_d     = nx[9:0];
          y_d     = ny[9:0];
          fly_t_d = fly_t_q + 1'b1;
          if (fly_t_d == FT_W'(ESCAPE_FRAMES)) state_d = S_ESCAPE;
        end
      end
      S_HIT: begin
        if (frame_tick) begin
          hit_t_d = hit_t_q + 1'b1;
          if (hit_t_d == HT_W'(HIT_FRAMES)) state_d = S_FALL;
        end
      end
      S_FALL: begin
        if (frame_tick) begin
          ny = {1'b0, y_q} + FALL_D;
          if (ny >= Y_MAX) begin ny = Y_MAX; state_d = S_DONE; end
          y_d = ny[9:0];
        end
      end
      S_ESCAPE: begin
        if (frame_tick) begin
          if ({1'b0, y_q} <= FLY_D) begin
            y_d = '0; state_d = S_DONE; esc_d = 1'b1;
          end else begin
            y_d = y_q - FLY_D[9:0];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (frame_tick && (state_q == S_FLY || state_q == S_ESCAPE)) begin
      if (flap_cnt_q == FP_W'(FLAP_PERIOD - 1)) begin
        flap_cnt_d = '0;
        flap_d     = ~flap_q;
      end else begin
        flap_cnt_d = flap_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      x_q        <= '0;
      y_q        <= Y_MAX[9:0];
      dir_x_q    <= 1'b0;
      dir_y_q    <= 1'b0;
      fly_t_q    <= '0;
      hit_t_q    <= '0;
      flap_cnt_q <= '0;
      flap_q     <= 1'b0;
      hit        <= 1'b0;
      escaped    <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      dir_x_q    <= dir_x_d;
      dir_y_q    <= dir_y_d;
      fly_t_q    <= fly_t_d;
      hit_t_q    <= hit_t_d;
      flap_cnt_q <= flap_cnt_d;
      flap_q     <= flap_d;
      hit        <= hit_d;
      escaped    <= esc_d;
    end
  end

  assign duck_x = x_q;
  assign duck_y = y_q;
  assign state  = state_q;

  // Pixel path: stage 1 = ROM read + box/flash flags, stage 2 = output mux.
  logic [1:0]    sprite_frame;
  logic [XW-1:0] rel_x;
  logic [YW-1:0] rel_y;
  logic          in_box, flash_now;
  logic          vis_q, flash_q;
  logic [3:0]    rom_data;

  always_comb begin
    case (state_q)
      S_FLY, S_ESCAPE: sprite_frame = flap_q ? FRAME_FLAP1 : FRAME_FLAP0;
      S_HIT:           sprite_frame = FRAME_HIT;
      S_FALL:          sprite_frame = FRAME_FALL;
      default:         sprite_frame = FRAME_FLAP0;
    endcase
  end

  assign rel_x  = DrawX[XW-1:0] - x_q[XW-1:0];
  assign rel_y  = DrawY[YW-1:0] - y_q[YW-1:0];
  assign in_box = (state_q != S_IDLE) && (state_q != S_DONE)
               && ({1'b0, DrawX} >= {1'b0, x_q})
               && ({1'b0, DrawX} <  {1'b0, x_q} + 11'(SPRITE_W))
               && ({1'b0, DrawY} >= {1'b0, y_q})
               && ({1'b0, DrawY} <  {1'b0, y_q} + 11'(SPRITE_H));

`ifdef DUCK_HIT_FLASH_EN
  // 4-frame windows of the hit pause, the first one flashed.
  assign flash_now = (state_q == S_HIT) && !hit_t_q[2];
`else
  assign flash_now = 1'b0;
`endif

  duck_sprite_rom #(
    .SPRITE_W (SPRITE_W),
    .SPRITE_H (SPRITE_H)
  ) u_rom (
    .clk   (Clk),
    .reset (Reset),
    .addr  ({sprite_frame, rel_y, rel_x}),
    .data  (rom_data)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      vis_q      <= 1'b0;
      flash_q    <= 1'b0;
      duck_pixel <= 1'b0;
      color_idx  <= IDX_TRANSPARENT;
    end else begin
      vis_q   <= in_box;
      flash_q <= flash_now;
      if (vis_q && rom_data != IDX_TRANSPARENT) begin
        duck_pixel <= 1'b1;
        color_idx  <= flash_q ? IDX_FLASH : rom_data;
      end else begin
        duck_pixel <= 1'b0;
        color_idx  <= IDX_TRANSPARENT;
      end
    end
  end

  logic [AW-1:0] unused_aw;
  assign unused_aw = '0;

endmodule

// File: doc/duck_sprite_ctrl.md
DUCK_SPRITE_CTRL -- requirements
Module: duck_sprite_ctrl

Interface
REQ-001: Parameter SPRITE_W, 32, duck sprite width in pixels.
REQ-002: Parameter SPRITE_H, 32, duck sprite height in pixels.
REQ-003: Parameter SCREEN_W, 640, visible width; GROUND_Y, 400, y at which fall ends.
REQ-004: Parameter FLY_SPEED, 2, pixels per frame on each axis; FALL_SPEED, 4, pixels per frame while falling.
REQ-005: Parameter FLAP_PERIOD, 8, frames per wing frame; HIT_FRAMES, 30, hit pause; ESCAPE_FRAMES, 600, fly time before escape.
REQ-006: Clk  in  1  system clock, all logic on rising edge.
REQ-007: Reset  in  1  synchronous, active-high reset.
REQ-008: frame_tick  in  1  one-cycle pulse per video frame.
REQ-009: start  in  1  one-cycle pulse launching a duck; start_x  in  10  launch x; start_dir  in  1  0=left, 1=right.
REQ-010: shot  in  1  one-cycle trigger pulse; shot_x, shot_y  in  10 each  crosshair position at trigger.
REQ-011: DrawX, DrawY  in  10 each  current pixel coordinate from the VGA controller.
REQ-012: color_idx  out  4  palette index for the current pixel; duck_pixel  out  1  duck layer opaque at this pixel.
REQ-013: duck_x, duck_y  out  10 each  sprite top-left; state  out  3  current FSM state.
REQ-014: hit, escaped  out  1 each  one-cycle event pulses.

Function
REQ-015: FSM states SHALL be IDLE, FLY, HIT, FALL, ESCAPE, DONE.
REQ-016: IDLE/DONE + start -> FLY, duck_x=start_x clamped to SCREEN_W-SPRITE_W, duck_y=GROUND_Y, dir_x=start_dir, dir_y=up, fly timer=0; start in any other state SHALL be ignored.
REQ-017: FLY: on frame_tick, x and y SHALL move FLY_SPEED in dir_x/dir_y, computed 11-bit; crossing 0 or SCREEN_W-SPRITE_W (x), or 0 or GROUND_Y (y), SHALL clamp to the bound and invert that direction.
REQ-018: FLY + shot with shot_x in [duck_x, duck_x+SPRITE_W) and shot_y in [duck_y, duck_y+SPRITE_H) -> HIT with hit pulsed next cycle; shots outside FLY or outside box SHALL be ignored.
REQ-019: FLY: fly timer counts frame_ticks; reaching ESCAPE_FRAMES -> ESCAPE; if a valid hit and timer expiry coincide, hit SHALL win.
REQ-020: HIT: position frozen; after HIT_FRAMES frame_ticks -> FALL.
REQ-021: FALL: y += FALL_SPEED per frame_tick, clamped at GROUND_Y; on reaching GROUND_Y -> DONE.
REQ-022: ESCAPE: y -= FLY_SPEED per frame_tick, x frozen, clamped at 0; on reaching 0 -> DONE with escaped pulsed one cycle.
REQ-023: Sprite frame SHALL be 0/1 alternating every FLAP_PERIOD ticks in FLY and ESCAPE, 2 in HIT, 3 in FALL.
REQ-024: Pixel path: DrawX/DrawY inside sprite box -> ROM address {frame, DrawY-duck_y, DrawX-duck_x}; color_idx and duck_pixel SHALL appear exactly 2 Clk cycles after DrawX/DrawY.
REQ-025: Outside box, in IDLE/DONE, or ROM value 4'hF (transparent), duck_pixel SHALL be 0 and color_idx 4'hF.

Reset
REQ-026: Reset SHALL force IDLE, duck_x=0, duck_y=GROUND_Y, timers and frame counter 0, hit=escaped=duck_pixel=0, color_idx=4'hF, including mid-flight; pixel pipeline registers SHALL clear the same cycle.

Configuration
REQ-027: With DUCK_HIT_FLASH_EN defined, in HIT every opaque pixel SHALL output color_idx 4'h1 during alternating 4-frame windows (first window flashed); without it HIT SHALL show sprite frame 2 unmodified.

Structure
REQ-028: Package duck_pkg SHALL hold the state enum, IDX_TRANSPARENT=4'hF, IDX_FLASH=4'h1, and sprite frame numbers.
REQ-029: Sprite storage SHALL be sub-module duck_sprite_rom (synchronous read, 1-cycle latency, 4 frames x SPRITE_H x SPRITE_W x 4 bits).

Verification
REQ-030: start, start_x=100, start_dir=1; 3 frame_ticks -> duck_x=106, duck_y=394, state=FLY.
REQ-031: duck_x=606 moving right, frame_tick -> duck_x=608 clamped, dir_x left; next tick -> 606.
REQ-032: shot at (duck_x+5, duck_y+5) in FLY -> hit pulse 1 cycle, HIT; 30 ticks -> FALL; reaches y=400 -> DONE.
REQ-033: No shot for 600 ticks -> ESCAPE; y decreases 2/tick to 0 -> escaped pulse, DONE; shot on same cycle as expiry -> HIT instead.
REQ-034: DrawX/DrawY stepped over sprite box -> color_idx matches ROM contents 2 cycles later, 4'hF/duck_pixel=0 on transparent and outside pixels.
REQ-035: Reset asserted in FALL -> next cycle state=IDLE, all outputs at reset values; with DUCK_HIT_FLASH_EN, HIT pixels alternate 4'h1/ROM every 4 ticks.
